// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio: data-memory responder for the single-cycle MIPS core.
// Decodes the core's byte address into a word RAM and a small peripheral page:
// a free-running timer with a sticky compare flag, and an 8N1 UART transmitter.
//
// Ports:
//   clk          rising-edge system clock
//   rst          asynchronous, active-high reset
//   addr         byte address from the core (aluresult); addr[1:0] ignored
//   wdata        store data from the core
//   memwrt       store strobe, takes effect at the rising clk edge
//   rdata        load data, combinational from addr and current state
//   uart_tx      serial output, LSB first, idles high (registered)
//   timer_match  sticky compare flag, STATUS bit1 (registered)
module mips_dmem_mmio #(
    parameter int DEPTH   = 64,
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrt,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        timer_match
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [31:0] mem [DEPTH];

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic [7:0]  txdata_q;
    tx_state_t   state_q;
    logic [2:0]  idx_q;
    logic [DW-1:0] div_q;
    logic        tx_q;

    // Byte offset within a word is meaningless to a word-only responder.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // Address decode on the word address.
    logic          is_ram, is_page;
    logic [AW-1:0] ram_idx;
    logic          wr_count, wr_cmp, wr_status, wr_tx;

    assign is_ram  = (addr[31:AW+2] == '0);
    assign ram_idx = addr[AW+1:2];
    assign is_page = (addr[31:4] == 28'hFFFF000);

    assign wr_count  = memwrt && is_page && (addr[3:2] == 2'd0);
    assign wr_cmp    = memwrt && is_page && (addr[3:2] == 2'd1);
    assign wr_status = memwrt && is_page && (addr[3:2] == 2'd2);
    assign wr_tx     = memwrt && is_page && (addr[3:2] == 2'd3);

    logic tx_busy;
    assign tx_busy = (state_q != IDLE);

    // RAM: full-word writes, combinational reads, contents survive reset.
    always_ff @(posedge clk) begin
        if (memwrt && is_ram) begin
            mem[ram_idx] <= wdata;
        end
    end

    // Timer next state. Match is judged on the pre-write COUNT, and a match
    // beats a simultaneous clear so no event is ever lost.
    always_comb begin
        count_d = wr_count ? wdata : count_q + 32'd1;
        cmp_d   = wr_cmp ? wdata : cmp_q;
        match_d = match_q;
        if (count_q == cmp_q) begin
            match_d = 1'b1;
        end else if (wr_status && wdata[1]) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    // UART transmitter. tx_q is loaded with the level of the state being
    // entered, so the line is a clean flop output. A TXDATA write is only
    // looked at in IDLE, which both ignores writes while busy and forces at
    // least one idle cycle between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            txdata_q <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_tx) begin
                        txdata_q <= wdata[7:0];
                        state_q  <= START;
                        div_q    <= '0;
                        tx_q     <= 1'b0;
                    end
                end
                START: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        idx_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= txdata_q[0];
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                DATA: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= txdata_q[idx_q + 3'd1];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                STOP: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Read mux: reflects state before the current edge, no write forwarding.
    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = mem[ram_idx];
        end else if (is_page) begin
            case (addr[3:2])
                2'd0:    rdata = count_q;
                2'd1:    rdata = cmp_q;
                2'd2:    rdata = {30'd0, match_q, tx_busy};
                default: rdata = {24'd0, txdata_q};
            endcase
        end
    end

    assign uart_tx     = tx_q;
    assign timer_match = match_q;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
module tb_mips_dmem_mmio;
    localparam int DEPTH   = 64;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        memwrt = 1'b0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        timer_match;

    mips_dmem_mmio #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .memwrt(memwrt),
        .rdata(rdata), .uart_tx(uart_tx), .timer_match(timer_match)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain state plus a frame timeline measured in edges.
    logic [31:0] m_ram [DEPTH];
    bit          m_ramv [DEPTH];
    logic [31:0] m_count, m_cmp;
    bit          m_flag;
    logic [7:0]  m_tx;
    int          ecnt, fstart;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_count = '0; m_cmp = 32'hFFFF_FFFF; m_flag = 0; m_tx = '0;
        ecnt = 0; fstart = -100000;
    endfunction

    function automatic bit m_busy();
        return (ecnt - fstart) < 10 * CLK_DIV;
    endfunction

    // Frame slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    function automatic logic m_txbit();
        int p, b;
        p = ecnt - fstart;
        if (p >= 10 * CLK_DIV) return 1'b1;
        b = p / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_tx[b-1];
    endfunction

    function automatic bit m_is_ram(input logic [31:0] a);
        return a < DEPTH * 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (m_is_ram(a)) return m_ram[a[31:2] % DEPTH];
        if (wa == A_COUNT)  return m_count;
        if (wa == A_CMP)    return m_cmp;
        if (wa == A_STATUS) return {30'd0, m_flag, m_busy()};
        if (wa == A_TXDATA) return {24'd0, m_tx};
        return 32'd0;
    endfunction

    function automatic void m_edge(input logic [31:0] a, input logic [31:0] wd, input logic we);
        logic [31:0] wa;
        bit hit, idle;
        wa   = {a[31:2], 2'b00};
        hit  = (m_count == m_cmp);
        idle = !m_busy();
        if (we && m_is_ram(a)) begin
            m_ram[a[31:2] % DEPTH] = wd;
            m_ramv[a[31:2] % DEPTH] = 1;
        end
        if (hit) m_flag = 1;
        else if (we && wa == A_STATUS && wd[1]) m_flag = 0;
        if (we && wa == A_CMP) m_cmp = wd;
        m_count = (we && wa == A_COUNT) ? wd : m_count + 32'd1;
        ecnt++;
        if (we && wa == A_TXDATA && idle) begin
            m_tx = wd[7:0];
            fstart = ecnt;
        end
    endfunction

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we);
        addr = a; wdata = wd; memwrt = we;
        #1;
        chk("uart_tx", {31'd0, uart_tx}, {31'd0, m_txbit()});
        chk("timer_match", {31'd0, timer_match}, {31'd0, m_flag});
        if (!m_is_ram(a) || m_ramv[a[31:2] % DEPTH])
            chk("rdata", rdata, m_read(a));
        @(posedge clk);
        m_edge(a, wd, we);
        #1;
        memwrt = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; memwrt = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_busy(); i++) step(A_STATUS, 0, 0);
        chk("idle_budget", {31'd0, m_busy()}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1: return 32'($urandom_range(0, DEPTH * 4 - 1));
            2, 3: return 32'hFFFF_0000 + 32'($urandom_range(0, 15));
            4:    return 32'hFFFF_0010 + 32'($urandom_range(0, 255));
            default: return 32'h0000_0100 + 32'($urandom_range(0, 65535));
        endcase
    endfunction

    logic [9:0] pat;
    logic [31:0] ra;

    initial begin
        pat = 10'b1_1010_0101_0;  // stop, 0xA5 MSB..LSB, start (bit 0 first)
        for (int i = 0; i < DEPTH; i++) m_ramv[i] = 0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_match", {31'd0, timer_match}, 32'd0);
        peek("rst_status", A_STATUS, 32'd0);
        peek("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        peek("rst_count", A_COUNT, 32'd0);
        rst = 1'b0;

        // RAM fill, then directed RAM and unmapped reads.
        for (int i = 0; i < DEPTH; i++) step(32'(i * 4), $urandom, 1);
        step(32'h8, 32'hDEAD_BEEF, 1);
        step(32'hC, 32'h1234_5678, 1);
        peek("ram_8", 32'h8, 32'hDEAD_BEEF);
        peek("ram_c", 32'hC, 32'h1234_5678);
        peek("ram_oob", 32'h10C, 32'd0);
        peek("unmapped", 32'hFFFF_0010, 32'd0);
        step(32'h8, 0, 0);

        // Timer wrap.
        step(A_COUNT, 32'hFFFF_FFFE, 1);
        step(A_COUNT, 0, 0);
        step(A_COUNT, 0, 0);
        peek("wrap_0", A_COUNT, 32'd0);
        step(A_COUNT, 0, 0);
        peek("wrap_1", A_COUNT, 32'd1);

        // Compare at 100, then clear.
        step(A_STATUS, 32'h2, 1);
        step(A_CMP, 32'd100, 1);
        step(A_COUNT, 32'd0, 1);
        for (int i = 0; i < 200 && m_count != 32'd100; i++) step(A_STATUS, 0, 0);
        chk("pre_match", {31'd0, timer_match}, 32'd0);
        step(A_COUNT, 0, 0);
        chk("match_rise", {31'd0, timer_match}, 32'd1);
        peek("match_status", A_STATUS, 32'h2);
        step(A_STATUS, 32'h2, 1);
        peek("match_clear", A_STATUS, 32'h0);

        // Clear issued in the match cycle: set wins.
        step(A_CMP, m_count + 32'd6, 1);
        for (int i = 0; i < 20 && m_count != m_cmp; i++) step(A_STATUS, 0, 0);
        step(A_STATUS, 32'h2, 1);
        chk("clr_vs_set", {31'd0, timer_match}, 32'd1);
        step(A_STATUS, 32'h2, 1);

        // UART frame of 0xA5 with an ignored mid-frame write.
        wait_idle();
        step(A_TXDATA, 32'hA5, 1);
        for (int i = 0; i < 10 * CLK_DIV; i++) begin
            addr = A_STATUS;
            #1;
            chk("uart_seq", {31'd0, uart_tx}, {31'd0, pat[i / CLK_DIV]});
            chk("busy_frame", {31'd0, rdata[0]}, 32'd1);
            if (i == 10) step(A_TXDATA, 32'h3C, 1);
            else step(A_TXDATA, 0, 0);
        end
        peek("busy_after", A_STATUS, 32'd0);
        peek("txdata_kept", A_TXDATA, 32'hA5);
        chk("idle_line", {31'd0, uart_tx}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ra = rand_addr();
            if ($urandom_range(0, 9) == 0) step(A_CMP, m_count + 32'($urandom_range(2, 40)), 1);
            else step(ra, $urandom, ($urandom_range(0, 3) == 0));
        end

        // Reset during data bit 3 of a frame.
        wait_idle();
        step(A_TXDATA, 32'h5A, 1);
        for (int i = 0; i < 4 * CLK_DIV + 2; i++) step(A_STATUS, 0, 0);
        chk("pre_rst_bit3", {31'd0, uart_tx}, 32'd1);  // 0x5A bit 3 is 1
        step(A_STATUS, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, uart_tx}, 32'd1);
        peek("rst_async_status", A_STATUS, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        peek("post_rst_count", A_COUNT, 32'd0);
        step(A_COUNT, 0, 0);
        peek("post_rst_count1", A_COUNT, 32'd1);
        for (int i = 0; i < 50; i++) step(rand_addr(), $urandom, ($urandom_range(0, 3) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
